// File: rtl/multi_int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Holds the CP0 select codes, status bit positions, default vectors, FSM states and stack entry layout.
// Also holds the fixed-priority encoder.
package int_pkg;

  localparam logic [1:0]  CP0_STATUS     = 2'd0;
  localparam logic [1:0]  CP0_EPC        = 2'd1;
  localparam logic [1:0]  CP0_PEND       = 2'd2;
  localparam int          STATUS_IE_BIT  = 31;
  localparam logic [31:0] DEF_ISR_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_ISR_STRIDE = 32'h0000_0040;

  typedef enum logic {ST_IDLE, ST_ENTER} int_state_t;

  // prev_vld=0 encodes "no interrupt level", i.e. the stack was empty before this push
  typedef struct packed {
    logic [31:0] epc;
    logic        prev_vld;
    logic [2:0]  prev_id;
  } stk_ent_t;

  function automatic logic [2:0] prio_enc(input logic [7:0] req);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_int_ctrl_if.sv
// Bundles the pipeline-facing and CP0-facing signals of the interrupt controller.
// The master side is the core and pipeline. The slave side is the controller.
interface multi_int_ctrl_if #(parameter int N_SRC = 3);
  logic [N_SRC-1:0] irq_i;
  logic             take_ok;
  logic             eret_i;
  logic [31:0]      npc_i;
  logic             mtc0_we;
  logic [1:0]       cp0_sel;
  logic [31:0]      cp0_wdata;
  logic [31:0]      cp0_rdata;
  logic             interrupt;
  logic [31:0]      isr_entry;
  logic [31:0]      epc;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic             stack_err;

  modport master (
    output irq_i, take_ok, eret_i, npc_i, mtc0_we, cp0_sel, cp0_wdata,
    input  cp0_rdata, interrupt, isr_entry, epc, pending, in_service, stack_err
  );
  modport slave (
    input  irq_i, take_ok, eret_i, npc_i, mtc0_we, cp0_sel, cp0_wdata,
    output cp0_rdata, interrupt, isr_entry, epc, pending, in_service, stack_err
  );
endinterface

// File: rtl/multi_int_ctrl_epc_stack.sv
// LIFO that stores return addresses and interrupt levels. It supports push, pop and overwrite of the top entry.
// Writes take effect on the next clock edge and the top entry is read combinationally.
// A push when full or a pop when empty is ignored. Push has priority over pop, and pop over overwrite.
module epc_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic         ovr,
  input  logic [W-1:0] push_dat,
  input  logic [W-1:0] ovr_dat,
  output logic [W-1:0] top_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW:0]   cnt_q;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_idx;

  assign top_idx = PW'(cnt_q - (PW+1)'(1));
  assign wr_idx  = cnt_q[PW-1:0];
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_dat = mem[top_idx];

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_dat;
      cnt_q       <= cnt_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - (PW+1)'(1);
    end else if (ovr && !empty) begin
      mem[top_idx] <= ovr_dat;
    end
  end
endmodule

// File: rtl/multi_int_ctrl.sv
// Vectored, nesting interrupt controller with CP0 status, EPC and pending registers.
// An edge is pending one cycle after it is sampled, and the registered redirect pulse follows one cycle later.
// When take_ok is low, a request waits in pending indefinitely. A request is not lost when the stack is full.
module multi_int_ctrl
  import int_pkg::*;
#(
  parameter int          N_SRC       = 3,
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] ISR_BASE    = DEF_ISR_BASE,
  parameter logic [31:0] ISR_STRIDE  = DEF_ISR_STRIDE
) (
  input logic             clk,
  input logic             RST,
  multi_int_ctrl_if.slave bus
);
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  int_state_t       st_q, st_d;
  logic [N_SRC-1:0] irq_q, pend_q, mask_q, insvc_q;
  logic             ie_q, cur_vld_q, err_q;
  logic [2:0]       cur_id_q;
  logic [31:0]      isr_q, rdata, top_epc;
  logic [N_SRC-1:0] rise, elig, win_oh, restore_oh;
  logic [2:0]       win;
  logic             accept, do_pop, ovr_we, stk_full, stk_empty;
  stk_ent_t         top_ent, push_ent, ovr_ent;
  logic             unused_wdata;

  assign rise       = bus.irq_i & ~irq_q;
  assign elig       = pend_q & mask_q & {N_SRC{ie_q}};
  assign win        = prio_enc(8'(elig));
  assign win_oh     = ONE << win;
  assign restore_oh = top_ent.prev_vld ? (ONE << top_ent.prev_id) : '0;
  assign do_pop     = bus.eret_i && !stk_empty;
  assign ovr_we     = bus.mtc0_we && (bus.cp0_sel == CP0_EPC) && !stk_empty;
  assign push_ent   = '{epc: bus.npc_i, prev_vld: cur_vld_q, prev_id: cur_id_q};
  assign ovr_ent    = '{epc: bus.cp0_wdata, prev_vld: top_ent.prev_vld, prev_id: top_ent.prev_id};
  assign top_epc    = stk_empty ? 32'h0 : top_ent.epc;
  assign unused_wdata = ^bus.cp0_wdata[30:N_SRC];

  always_comb begin
    st_d   = st_q;
    accept = 1'b0;
    case (st_q)
      ST_IDLE: begin
        // A pending eret takes precedence. The request is evaluated again against the restored level.
        if ((|elig) && (!cur_vld_q || (win > cur_id_q)) && !stk_full &&
            bus.take_ok && !bus.eret_i) begin
          accept = 1'b1;
          st_d   = ST_ENTER;
        end
      end
      ST_ENTER: st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      st_q      <= ST_IDLE;
      irq_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      ie_q      <= 1'b0;
      insvc_q   <= '0;
      cur_vld_q <= 1'b0;
      cur_id_q  <= '0;
      err_q     <= 1'b0;
      isr_q     <= '0;
    end else begin
      st_q   <= st_d;
      irq_q  <= bus.irq_i;
      pend_q <= (pend_q & ~(accept ? win_oh : '0)) | rise;
      if (bus.mtc0_we && (bus.cp0_sel == CP0_STATUS)) begin
        ie_q   <= bus.cp0_wdata[STATUS_IE_BIT];
        mask_q <= bus.cp0_wdata[N_SRC-1:0];
      end
      if (accept) begin
        cur_vld_q <= 1'b1;
        cur_id_q  <= win;
        insvc_q   <= win_oh;
        isr_q     <= ISR_BASE + 32'(win) * ISR_STRIDE;
      end else if (do_pop) begin
        cur_vld_q <= top_ent.prev_vld;
        cur_id_q  <= top_ent.prev_id;
        insvc_q   <= restore_oh;
      end
      if (bus.eret_i && stk_empty) err_q <= 1'b1;
    end
  end

  epc_stack #(.DEPTH(STACK_DEPTH), .W($bits(stk_ent_t))) u_stack (
    .clk      (clk),
    .RST      (RST),
    .push     (accept),
    .pop      (do_pop),
    .ovr      (ovr_we),
    .push_dat (push_ent),
    .ovr_dat  (ovr_ent),
    .top_dat  (top_ent),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_comb begin
    rdata = '0;
    case (bus.cp0_sel)
      CP0_STATUS: begin
        rdata[STATUS_IE_BIT] = ie_q;
        rdata[N_SRC-1:0]     = mask_q;
      end
      CP0_EPC:  rdata = top_epc;
      CP0_PEND: rdata[N_SRC-1:0] = pend_q;
      default:  rdata = '0;
    endcase
  end

  assign bus.cp0_rdata  = rdata;
  assign bus.interrupt  = (st_q == ST_ENTER);
  assign bus.isr_entry  = isr_q;
  assign bus.epc        = top_epc;
  assign bus.pending    = pend_q;
  assign bus.in_service = insvc_q;
  assign bus.stack_err  = err_q;
endmodule

// File: tb/tb_multi_int_ctrl.sv
// Bench for multi_int_ctrl with N_SRC=3 and STACK_DEPTH=2.
// It uses directed vectors, a queue-based reference model and hand-computed pins.
module tb_multi_int_ctrl;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  multi_int_ctrl_if #(.N_SRC(3)) bus ();

  multi_int_ctrl #(.N_SRC(3), .STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Level -1 means that no ISR is running. The stack is a pair of queues.
  logic [2:0]  m_pend = '0, m_prev = '0, m_mask = '0;
  bit          m_ie = 0, m_err = 0, m_int = 0;
  int          m_level = -1;
  logic [31:0] m_entry = '0;
  logic [31:0] m_epc_q[$];
  int          m_lvl_q[$];

  always @(posedge clk) begin : model
    int win;
    bit take;
    logic [2:0] np;
    if (RST) begin
      m_pend = '0; m_prev = '0; m_mask = '0; m_ie = 0; m_err = 0; m_int = 0;
      m_level = -1; m_entry = '0; m_epc_q.delete(); m_lvl_q.delete();
    end else begin
      win = -1;
      for (int k = 0; k < 3; k++) if (m_pend[k] && m_mask[k] && m_ie) win = k;
      take = !m_int && (win > m_level) && (m_epc_q.size() < DEPTH) &&
             bus.take_ok && !bus.eret_i;
      np = m_pend;
      if (take) np[win] = 1'b0;
      np = np | (bus.irq_i & ~m_prev);
      m_prev = bus.irq_i;
      if (bus.eret_i) begin
        if (m_epc_q.size() > 0) begin
          m_level = m_lvl_q.pop_back();
          void'(m_epc_q.pop_back());
        end else m_err = 1;
      end else if (take) begin
        m_epc_q.push_back(bus.npc_i);
        m_lvl_q.push_back(m_level);
        m_level = win;
        m_entry = 32'h100 + 32'(win) * 32'h40;
      end else if (bus.mtc0_we && bus.cp0_sel == 2'd1 && m_epc_q.size() > 0) begin
        m_epc_q[m_epc_q.size()-1] = bus.cp0_wdata;
      end
      if (bus.mtc0_we && bus.cp0_sel == 2'd0) begin
        m_ie   = bus.cp0_wdata[31];
        m_mask = bus.cp0_wdata[2:0];
      end
      m_pend = np;
      m_int  = take;
    end
  end

  function automatic logic [31:0] m_top();
    return (m_epc_q.size() > 0) ? m_epc_q[m_epc_q.size()-1] : 32'h0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return {m_ie, 28'h0, m_mask};
      2'd1:    return m_top();
      2'd2:    return {29'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_interrupt", {31'h0, bus.interrupt}, {31'h0, m_int});
      if (m_int) chk("m_isr_entry", bus.isr_entry, m_entry);
      chk("m_pending", {29'h0, bus.pending}, {29'h0, m_pend});
      chk("m_in_service", {29'h0, bus.in_service},
          (m_level >= 0) ? (32'h1 << m_level) : 32'h0);
      chk("m_stack_err", {31'h0, bus.stack_err}, {31'h0, m_err});
      if (bus.eret_i) chk("m_epc", bus.epc, m_top());
      chk("m_cp0_rdata", bus.cp0_rdata, m_rdata(bus.cp0_sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpw(input logic [1:0] sel, input logic [31:0] d);
    bus.mtc0_we = 1'b1; bus.cp0_sel = sel; bus.cp0_wdata = d;
    tick();
    bus.mtc0_we = 1'b0; bus.cp0_sel = 2'd0;
  endtask

  task automatic pulse(input int k);
    bus.irq_i[k] = 1'b1;
    tick();
    bus.irq_i[k] = 1'b0;
  endtask

  task automatic eret1(input logic [31:0] exp_epc);
    bus.eret_i = 1'b1;
    #1 chk("eret_epc", bus.epc, exp_epc);
    tick();
    bus.eret_i = 1'b0;
  endtask

  task automatic pin_take(input string nm, input logic [31:0] entry, input logic [2:0] svc);
    chk({nm, "_int"}, {31'h0, bus.interrupt}, 32'h1);
    chk({nm, "_entry"}, bus.isr_entry, entry);
    chk({nm, "_svc"}, {29'h0, bus.in_service}, {29'h0, svc});
  endtask

  initial begin
    bus.irq_i = '0; bus.take_ok = 1'b1; bus.eret_i = 1'b0; bus.npc_i = '0;
    bus.mtc0_we = 1'b0; bus.cp0_sel = 2'd0; bus.cp0_wdata = '0;
    tick(); tick();
    cmp_en = 1; RST = 1'b0;
    chk("rst_int", {31'h0, bus.interrupt}, 32'h0);
    chk("rst_entry", bus.isr_entry, 32'h0);
    chk("rst_pend", {29'h0, bus.pending}, 32'h0);
    chk("rst_svc", {29'h0, bus.in_service}, 32'h0);
    chk("rst_status", bus.cp0_rdata, 32'h0);

    // Single source 1 returning to 0x40
    cpw(2'd0, 32'h8000_0007);
    #1 chk("status_rd", bus.cp0_rdata, 32'h8000_0007);
    bus.npc_i = 32'h40;
    pulse(1);
    chk("t1_pend", {29'h0, bus.pending}, 32'h2);
    chk("t1_noint", {31'h0, bus.interrupt}, 32'h0);
    tick(); pin_take("t1", 32'h140, 3'b010);
    tick(); eret1(32'h40);
    chk("t1_svc0", {29'h0, bus.in_service}, 32'h0);

    // Nested: source 0, then source 2
    bus.npc_i = 32'h200; pulse(0);
    tick(); pin_take("t2a", 32'h100, 3'b001);
    bus.npc_i = 32'h180; pulse(2);
    tick(); pin_take("t2b", 32'h180, 3'b100);
    tick(); eret1(32'h180);
    chk("t2_svc1", {29'h0, bus.in_service}, 32'h1);
    eret1(32'h200);
    chk("t2_svc0", {29'h0, bus.in_service}, 32'h0);

    // take_ok holds a request, and an eret in the same cycle wins over it
    bus.npc_i = 32'h300; pulse(0); tick(); tick();
    bus.take_ok = 1'b0; pulse(1); tick(); tick();
    chk("t3_hold", {29'h0, bus.pending}, 32'h2);
    bus.take_ok = 1'b1; eret1(32'h300);
    chk("t3_eret_noint", {31'h0, bus.interrupt}, 32'h0);
    chk("t3_eret_pend", {29'h0, bus.pending}, 32'h2);
    bus.npc_i = 32'h340;
    tick(); pin_take("t3b", 32'h140, 3'b010);
    tick(); pulse(0);
    chk("t3_lowpend", {29'h0, bus.pending}, 32'h1);
    chk("t3_lownoint", {31'h0, bus.interrupt}, 32'h0);
    eret1(32'h340);
    bus.npc_i = 32'h380;
    tick(); pin_take("t3c", 32'h100, 3'b001);
    tick(); eret1(32'h380);

    // A masked source stays pending until its mask bit is set
    cpw(2'd0, 32'h8000_0003);
    pulse(2); tick();
    chk("t4_pend", {29'h0, bus.pending}, 32'h4);
    chk("t4_noint", {31'h0, bus.interrupt}, 32'h0);
    bus.cp0_sel = 2'd2;
    #1 chk("t4_pend_rd", bus.cp0_rdata, 32'h4);
    bus.npc_i = 32'h400;
    cpw(2'd0, 32'h8000_0007);
    tick(); pin_take("t4", 32'h180, 3'b100);
    tick(); eret1(32'h400);

    // Stack full, EPC overwrite, then eret on an empty stack
    bus.npc_i = 32'h500; pulse(0); tick(); tick();
    bus.npc_i = 32'h540; pulse(1);
    tick(); pin_take("t5b", 32'h140, 3'b010);
    tick(); pulse(2); tick(); tick();
    chk("t5_full_pend", {29'h0, bus.pending}, 32'h4);
    chk("t5_full_noint", {31'h0, bus.interrupt}, 32'h0);
    cpw(2'd1, 32'h1234);
    bus.cp0_sel = 2'd1;
    #1 chk("t5_ovr_rd", bus.cp0_rdata, 32'h1234);
    bus.cp0_sel = 2'd0;
    eret1(32'h1234);
    tick(); pin_take("t5c", 32'h180, 3'b100);
    tick(); eret1(32'h540); eret1(32'h500); eret1(32'h0);
    chk("t5_err", {31'h0, bus.stack_err}, 32'h1);

    // A new edge on the same source during its take re-sets pending
    bus.npc_i = 32'h600; bus.take_ok = 1'b0;
    bus.irq_i[1] = 1'b1; tick();
    bus.irq_i[1] = 1'b0; tick();
    bus.irq_i[1] = 1'b1; bus.take_ok = 1'b1;
    tick(); pin_take("t6", 32'h140, 3'b010);
    chk("t6_repend", {29'h0, bus.pending}, 32'h2);
    bus.irq_i[1] = 1'b0;
    tick(); eret1(32'h600);
    tick(); pin_take("t6b", 32'h140, 3'b010);
    tick();

    // Reset while in ENTER
    pulse(2);
    tick(); pin_take("t7", 32'h180, 3'b100);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("t7_int", {31'h0, bus.interrupt}, 32'h0);
    chk("t7_entry", bus.isr_entry, 32'h0);
    chk("t7_svc", {29'h0, bus.in_service}, 32'h0);
    chk("t7_err", {31'h0, bus.stack_err}, 32'h0);
    chk("t7_epc", bus.epc, 32'h0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
